// File: rtl/rob_pkg.sv
// rob_pkg: shared definitions for the multi-completion reorder buffer.
//   rob_state_e  - control FSM encoding (normal operation / serial rollback)
//   RD_W         - logical register index width
//   rob_idx_w()  - entry index width for a given DEPTH
package rob_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RECOVER = 1'b1
    } rob_state_e;

    localparam int RD_W = 5;

    // Index width for a buffer of 'depth' entries. Depth is a power of two >= 2.
    function automatic int rob_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rob_ptr_ctrl.sv
// rob_ptr_ctrl: head/tail pointers for the reorder buffer.
// Pointers carry one extra wrap bit above the entry index so that the
// full and empty cases are distinguishable when the indices are equal.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   head_inc       - retire: advance head
//   tail_inc       - dispatch: advance tail
//   tail_dec       - rollback: step tail back by one
//   head, tail     - pointers (IW+1 bits, MSB is the wrap bit)
//   full, empty    - occupancy flags
//   count          - tail - head modulo 2^(IW+1)
module rob_ptr_ctrl
    import rob_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int IW = rob_idx_w(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        head_inc,
    input  logic        tail_inc,
    input  logic        tail_dec,
    output logic [IW:0] head,
    output logic [IW:0] tail,
    output logic        full,
    output logic        empty,
    output logic [IW:0] count
);

    localparam logic [IW:0] PTR_ONE = (IW+1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (head_inc) head <= head + PTR_ONE;
            // Dispatch and rollback never coincide; the guard keeps the
            // tail stable if both were ever requested together.
            if (tail_inc && !tail_dec)      tail <= tail + PTR_ONE;
            else if (tail_dec && !tail_inc) tail <= tail - PTR_ONE;
        end
    end

    assign full  = (head[IW-1:0] == tail[IW-1:0]) && (head[IW] != tail[IW]);
    assign empty = (head == tail);
    assign count = tail - head;

endmodule

// File: rtl/rob_multi_cmpl.sv
// rob_multi_cmpl: reorder buffer with NCMPL completion ports, in-order
// single retire, and serial youngest-first rollback after a retiring
// control-flow change.
// Handshake: dispatch is a one-sided valid/accept; an instruction is
// entered exactly in a cycle where dp_valid and dp_accept are both high,
// and dp_accept never depends on anything but registered state, dp_valid
// and hazard_stall. Completion ports are strobes with no back-pressure.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   dp_*                         - dispatch request, fields and tail index
//   cmpl_*                       - per-port completion (packed per port)
//   retire_*                     - head retirement outputs
//   change_flow_out/_addr        - fetch redirect on retiring branch
//   recover, rec_*               - rollback entry, youngest first
//   full, empty, count           - occupancy
//   dbg_state                    - current FSM state
module rob_multi_cmpl
    import rob_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PREG_W = 6,
    parameter int NCMPL  = 2,
    parameter int ADDR_W = 32,
    localparam int IW = rob_idx_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dp_valid,
    input  logic                    hazard_stall,
    input  logic                    dp_is_st,
    input  logic                    dp_reg_dest,
    input  logic [RD_W-1:0]         dp_rd,
    input  logic [PREG_W-1:0]       dp_pr_old,
    input  logic [PREG_W-1:0]       dp_pr_new,
    output logic [IW-1:0]           dp_rob_num,
    output logic                    dp_accept,
    input  logic [NCMPL-1:0]        cmpl_valid,
    input  logic [NCMPL*IW-1:0]     cmpl_rob_num,
    input  logic [NCMPL-1:0]        cmpl_change_flow,
    input  logic [NCMPL*ADDR_W-1:0] cmpl_jb_addr,
    output logic                    retire_reg,
    output logic                    retire_st,
    output logic                    retire_reg_dest,
    output logic [PREG_W-1:0]       retire_pr_old,
    output logic [IW-1:0]           retire_rob_num,
    output logic                    change_flow_out,
    output logic [ADDR_W-1:0]       change_flow_addr,
    output logic                    recover,
    output logic                    rec_reg_dest,
    output logic [RD_W-1:0]         rec_rd,
    output logic [PREG_W-1:0]       rec_pr_old,
    output logic [PREG_W-1:0]       rec_pr_new,
    output logic [IW-1:0]           rec_rob_num,
    output logic                    full,
    output logic                    empty,
    output logic [IW:0]             count,
    output rob_state_e              dbg_state
);

    localparam logic [IW:0] PTR_ONE = (IW+1)'(1);

    rob_state_e state, state_nxt;

    logic [IW:0]   head, tail, tail_m1;
    logic [IW-1:0] head_idx, tail_idx, last_idx;
    logic          head_inc, tail_inc, tail_dec;
    logic          head_ready;

    // Entry storage: control bits are reset, payload is not (it is only
    // observed through outputs gated by valid/done/state).
    logic [DEPTH-1:0]  e_valid, e_done, e_cf;
    logic [DEPTH-1:0]  e_is_st, e_reg_dest;
    logic [RD_W-1:0]   e_rd     [DEPTH];
    logic [PREG_W-1:0] e_pr_old [DEPTH];
    logic [PREG_W-1:0] e_pr_new [DEPTH];
    logic [ADDR_W-1:0] e_jb     [DEPTH];

    // Per-entry merge of all completion ports for this cycle.
    logic [DEPTH-1:0]  c_hit, c_cf;
    logic [ADDR_W-1:0] c_addr [DEPTH];

    rob_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .head_inc (head_inc),
        .tail_inc (tail_inc),
        .tail_dec (tail_dec),
        .head     (head),
        .tail     (tail),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign head_idx = head[IW-1:0];
    assign tail_idx = tail[IW-1:0];
    assign tail_m1  = tail - PTR_ONE;
    assign last_idx = tail_m1[IW-1:0];

    // Ports are scanned highest to lowest so the lowest-numbered port
    // carrying a redirect is the one whose target sticks.
    always_comb begin
        c_hit = '0;
        c_cf  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c_addr[i] = '0;
            for (int k = NCMPL - 1; k >= 0; k--) begin
                if (cmpl_valid[k] && (cmpl_rob_num[k*IW +: IW] == IW'(i))) begin
                    c_hit[i] = 1'b1;
                    if (cmpl_change_flow[k]) begin
                        c_cf[i]   = 1'b1;
                        c_addr[i] = cmpl_jb_addr[k*ADDR_W +: ADDR_W];
                    end
                end
            end
        end
    end

    assign head_ready = (state == ST_IDLE) && e_valid[head_idx] && e_done[head_idx];
    assign dp_accept  = dp_valid && !hazard_stall && !full && (state == ST_IDLE);

    // Next state and pointer moves.
    always_comb begin
        state_nxt = state;
        head_inc  = 1'b0;
        tail_inc  = 1'b0;
        tail_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                head_inc = head_ready;
                tail_inc = dp_accept;
                // Younger entries exist if anything besides the head is
                // occupied, or something is being dispatched right now.
                if (head_ready && e_cf[head_idx] && ((count > PTR_ONE) || dp_accept))
                    state_nxt = ST_RECOVER;
            end
            ST_RECOVER: begin
                tail_dec = 1'b1;
                if (tail_m1 == head) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Control bits. Later assignments win: dispatch over completion,
    // retire/rollback invalidation over everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid <= '0;
            e_done  <= '0;
            e_cf    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_valid[i] && c_hit[i]) begin
                    e_done[i] <= 1'b1;
                    if (c_cf[i]) e_cf[i] <= 1'b1;
                end
            end
            if (tail_inc) begin
                e_valid[tail_idx] <= 1'b1;
                e_done[tail_idx]  <= 1'b0;
                e_cf[tail_idx]    <= 1'b0;
            end
            if (head_inc) e_valid[head_idx] <= 1'b0;
            if (tail_dec) e_valid[last_idx] <= 1'b0;
        end
    end

    // Payload fields.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (e_valid[i] && c_cf[i]) e_jb[i] <= c_addr[i];
        end
        if (tail_inc) begin
            e_is_st[tail_idx]    <= dp_is_st;
            e_reg_dest[tail_idx] <= dp_reg_dest;
            e_rd[tail_idx]       <= dp_rd;
            e_pr_old[tail_idx]   <= dp_pr_old;
            e_pr_new[tail_idx]   <= dp_pr_new;
        end
    end

    assign dp_rob_num = tail_idx;

    assign retire_reg       = head_ready && e_reg_dest[head_idx];
    assign retire_st        = head_ready && e_is_st[head_idx];
    assign retire_reg_dest  = head_ready && e_reg_dest[head_idx];
    assign retire_pr_old    = head_ready ? e_pr_old[head_idx] : '0;
    assign retire_rob_num   = head_ready ? head_idx : '0;
    assign change_flow_out  = head_ready && e_cf[head_idx];
    assign change_flow_addr = (head_ready && e_cf[head_idx]) ? e_jb[head_idx] : '0;

    assign recover      = (state == ST_RECOVER);
    assign rec_reg_dest = recover && e_reg_dest[last_idx];
    assign rec_rd       = recover ? e_rd[last_idx] : '0;
    assign rec_pr_old   = recover ? e_pr_old[last_idx] : '0;
    assign rec_pr_new   = recover ? e_pr_new[last_idx] : '0;
    assign rec_rob_num  = recover ? last_idx : '0;

    assign dbg_state = state;

endmodule

// File: tb/tb_rob_multi_cmpl.sv
// tb_rob_multi_cmpl: self-checking bench for rob_multi_cmpl. A queue-based
// reference model (ordered list of in-flight instructions) predicts every
// output each cycle; scenario tasks add targeted checks.
module tb_rob_multi_cmpl;
    import rob_pkg::*;

    localparam int DEPTH  = 16;
    localparam int PREG_W = 6;
    localparam int NCMPL  = 2;
    localparam int ADDR_W = 32;
    localparam int IW     = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic                    dp_valid, hazard_stall, dp_is_st, dp_reg_dest;
    logic [4:0]              dp_rd;
    logic [PREG_W-1:0]       dp_pr_old, dp_pr_new;
    logic [IW-1:0]           dp_rob_num;
    logic                    dp_accept;
    logic [NCMPL-1:0]        cmpl_valid, cmpl_change_flow;
    logic [NCMPL*IW-1:0]     cmpl_rob_num;
    logic [NCMPL*ADDR_W-1:0] cmpl_jb_addr;
    logic                    retire_reg, retire_st, retire_reg_dest;
    logic [PREG_W-1:0]       retire_pr_old;
    logic [IW-1:0]           retire_rob_num;
    logic                    change_flow_out;
    logic [ADDR_W-1:0]       change_flow_addr;
    logic                    recover, rec_reg_dest;
    logic [4:0]              rec_rd;
    logic [PREG_W-1:0]       rec_pr_old, rec_pr_new;
    logic [IW-1:0]           rec_rob_num;
    logic                    full, empty;
    logic [IW:0]             count;
    rob_state_e              dbg_state;

    rob_multi_cmpl #(.DEPTH(DEPTH), .PREG_W(PREG_W), .NCMPL(NCMPL), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .dp_valid(dp_valid), .hazard_stall(hazard_stall), .dp_is_st(dp_is_st),
        .dp_reg_dest(dp_reg_dest), .dp_rd(dp_rd), .dp_pr_old(dp_pr_old), .dp_pr_new(dp_pr_new),
        .dp_rob_num(dp_rob_num), .dp_accept(dp_accept),
        .cmpl_valid(cmpl_valid), .cmpl_rob_num(cmpl_rob_num),
        .cmpl_change_flow(cmpl_change_flow), .cmpl_jb_addr(cmpl_jb_addr),
        .retire_reg(retire_reg), .retire_st(retire_st), .retire_reg_dest(retire_reg_dest),
        .retire_pr_old(retire_pr_old), .retire_rob_num(retire_rob_num),
        .change_flow_out(change_flow_out), .change_flow_addr(change_flow_addr),
        .recover(recover), .rec_reg_dest(rec_reg_dest), .rec_rd(rec_rd),
        .rec_pr_old(rec_pr_old), .rec_pr_new(rec_pr_new), .rec_rob_num(rec_rob_num),
        .full(full), .empty(empty), .count(count), .dbg_state(dbg_state)
    );

    // Snapshot of every DUT output, compared as a whole each cycle.
    typedef struct packed {
        logic [IW-1:0]     dp_rob_num;
        logic              dp_accept, full, empty;
        logic [IW:0]       count;
        logic              retire_reg, retire_st, retire_reg_dest;
        logic [PREG_W-1:0] retire_pr_old;
        logic [IW-1:0]     retire_rob_num;
        logic              change_flow_out;
        logic [ADDR_W-1:0] change_flow_addr;
        logic              recover, rec_reg_dest;
        logic [4:0]        rec_rd;
        logic [PREG_W-1:0] rec_pr_old, rec_pr_new;
        logic [IW-1:0]     rec_rob_num;
        logic              state;
    } snap_t;

    snap_t snap;
    always_comb begin
        snap = '0;
        snap.dp_rob_num       = dp_rob_num;
        snap.dp_accept        = dp_accept;
        snap.full             = full;
        snap.empty            = empty;
        snap.count            = count;
        snap.retire_reg       = retire_reg;
        snap.retire_st        = retire_st;
        snap.retire_reg_dest  = retire_reg_dest;
        snap.retire_pr_old    = retire_pr_old;
        snap.retire_rob_num   = retire_rob_num;
        snap.change_flow_out  = change_flow_out;
        snap.change_flow_addr = change_flow_addr;
        snap.recover          = recover;
        snap.rec_reg_dest     = rec_reg_dest;
        snap.rec_rd           = rec_rd;
        snap.rec_pr_old       = rec_pr_old;
        snap.rec_pr_new       = rec_pr_new;
        snap.rec_rob_num      = rec_rob_num;
        snap.state            = dbg_state;
    end

    // ---------------- reference model ----------------
    typedef struct {
        int                rob;
        logic              is_st, reg_dest, done, cf;
        logic [4:0]        rd;
        logic [PREG_W-1:0] pr_old, pr_new;
        logic [ADDR_W-1:0] addr;
    } ent_t;

    ent_t mq[$];        // in-flight instructions, oldest first
    int   m_tail;       // next index handed to dispatch
    bit   m_rec;        // rolling back younger instructions

    logic [PREG_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_clear();
        mq.delete();
        m_tail = 0;
        m_rec  = 0;
    endtask

    // ---------------- drivers ----------------
    task automatic clear_inputs();
        dp_valid = 0; hazard_stall = 0; dp_is_st = 0; dp_reg_dest = 0;
        dp_rd = '0; dp_pr_old = '0; dp_pr_new = '0;
        cmpl_valid = '0; cmpl_rob_num = '0; cmpl_change_flow = '0; cmpl_jb_addr = '0;
    endtask

    task automatic drive_dispatch(input bit force_reg);
        dp_valid    = 1'b1;
        dp_is_st    = 1'($urandom_range(0, 1));
        dp_reg_dest = force_reg ? 1'b1 : 1'($urandom_range(0, 1));
        dp_rd       = 5'($urandom_range(0, 31));
        dp_pr_old   = PREG_W'($urandom_range(0, 63));
        dp_pr_new   = PREG_W'($urandom_range(0, 63));
    endtask

    task automatic drive_cmpl(input int port, input int rob, input bit cf, input logic [ADDR_W-1:0] addr);
        cmpl_valid[port]                    = 1'b1;
        cmpl_rob_num[port*IW +: IW]         = IW'(rob);
        cmpl_change_flow[port]              = cf;
        cmpl_jb_addr[port*ADDR_W +: ADDR_W] = addr;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    // One cycle: predict outputs at the negedge, capture the DUT, advance
    // the model with the inputs seen at the posedge, then clear inputs.
    task automatic step(output snap_t o, output snap_t e);
        int n;
        bit ret, acc;
        ent_t h, ne;
        logic [DEPTH-1:0] cf_seen;
        ret = 0; acc = 0; e = '0;
        @(negedge clk);
        n = mq.size();
        e.dp_rob_num = IW'(m_tail);
        e.full       = (n == DEPTH);
        e.empty      = (n == 0);
        e.count      = (IW+1)'(n);
        if (m_rec) begin
            h = mq[n-1];
            e.recover      = 1'b1;
            e.rec_reg_dest = h.reg_dest;
            e.rec_rd       = h.rd;
            e.rec_pr_old   = h.pr_old;
            e.rec_pr_new   = h.pr_new;
            e.rec_rob_num  = IW'(h.rob);
            e.state        = 1'b1;
        end else begin
            acc = dp_valid && !hazard_stall && (n != DEPTH);
            e.dp_accept = acc;
            if (n > 0 && mq[0].done) begin
                ret = 1;
                e.retire_reg      = mq[0].reg_dest;
                e.retire_st       = mq[0].is_st;
                e.retire_reg_dest = mq[0].reg_dest;
                e.retire_pr_old   = mq[0].pr_old;
                e.retire_rob_num  = IW'(mq[0].rob);
                if (mq[0].cf) begin
                    e.change_flow_out  = 1'b1;
                    e.change_flow_addr = mq[0].addr;
                end
            end
        end
        o = snap;
        @(posedge clk);
        cf_seen = '0;
        for (int k = 0; k < NCMPL; k++) begin
            if (cmpl_valid[k]) begin
                for (int q = 0; q < mq.size(); q++) begin
                    if (mq[q].rob == int'(cmpl_rob_num[k*IW +: IW])) begin
                        h = mq[q];
                        h.done = 1'b1;
                        if (cmpl_change_flow[k]) begin
                            h.cf = 1'b1;
                            if (!cf_seen[h.rob]) h.addr = cmpl_jb_addr[k*ADDR_W +: ADDR_W];
                            cf_seen[h.rob] = 1'b1;
                        end
                        mq[q] = h;
                    end
                end
            end
        end
        if (m_rec) begin
            void'(mq.pop_back());
            m_tail = (m_tail + DEPTH - 1) % DEPTH;
            if (mq.size() == 0) m_rec = 0;
        end else begin
            h.cf = 1'b0;
            if (ret) h = mq.pop_front();
            if (acc) begin
                ne.rob = m_tail; ne.is_st = dp_is_st; ne.reg_dest = dp_reg_dest;
                ne.rd = dp_rd; ne.pr_old = dp_pr_old; ne.pr_new = dp_pr_new;
                ne.done = 0; ne.cf = 0; ne.addr = '0;
                mq.push_back(ne);
                m_tail = (m_tail + 1) % DEPTH;
            end
            if (ret && h.cf && mq.size() > 0) m_rec = 1;
        end
        #1 clear_inputs();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        snap_t r, o, e;
        r = '0;
        r.empty = 1'b1;
        clear_inputs();
        rst = 1'b1;
        #2;
        n_checks++;
        if (snap !== r) begin n_fail++; $display("FAIL reset_value got %h exp %h", snap, r); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        step(o, e);
        n_checks++;
        if (o !== r) begin n_fail++; $display("FAIL reset_idle got %h exp %h", o, r); end
    endtask

    task automatic test_fill_drain();
        snap_t o, e;
        logic [PREG_W-1:0] pv, want;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            drive_dispatch(1);
            pv = dp_pr_old;
            step(o, e);
            if (e.dp_accept) exp_q.push_back(pv);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL fill_%0d got %h exp %h", i, o, e); end
        end
        drive_dispatch(1);
        step(o, e);
        n_checks++;
        if (o.full !== 1'b1 || o.count !== 5'd16 || o.dp_accept !== 1'b0) begin
            n_fail++;
            $display("FAIL full_reject got full=%b count=%0d acc=%b exp 1 16 0", o.full, o.count, o.dp_accept);
        end
        for (int j = 0; j <= DEPTH; j++) begin
            if (j < DEPTH) drive_cmpl($urandom_range(0, NCMPL - 1), j, 0, '0);
            step(o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL drain_%0d got %h exp %h", j, o, e); end
            if (j >= 1) begin
                want = exp_q.pop_front();
                n_checks++;
                if (o.retire_reg !== 1'b1 || o.retire_rob_num !== IW'(j - 1) || o.retire_pr_old !== want) begin
                    n_fail++;
                    $display("FAIL retire_order_%0d got %b/%0d/%h exp 1/%0d/%h",
                             j - 1, o.retire_reg, o.retire_rob_num, o.retire_pr_old, j - 1, want);
                end
            end
        end
        step(o, e);
        n_checks++;
        if (o.empty !== 1'b1 || o.count !== 5'd0) begin
            n_fail++; $display("FAIL drain_empty got empty=%b count=%0d exp 1 0", o.empty, o.count);
        end
    endtask

    task automatic test_out_of_order();
        snap_t o, e;
        do_reset();
        for (int i = 0; i < 3; i++) begin drive_dispatch(1); step(o, e); end
        drive_cmpl(0, 2, 0, '0);
        drive_cmpl(1, 1, 0, '0);
        step(o, e);
        n_checks++;
        if (o !== e || o.retire_reg !== 1'b0) begin n_fail++; $display("FAIL ooo_hold got %h exp %h", o, e); end
        drive_cmpl(0, 0, 0, '0);
        step(o, e);
        for (int k = 0; k < 3; k++) begin
            step(o, e);
            n_checks++;
            if (o !== e || o.retire_reg !== 1'b1 || o.retire_rob_num !== IW'(k)) begin
                n_fail++; $display("FAIL ooo_retire_%0d got rob=%0d ret=%b exp rob=%0d ret=1", k, o.retire_rob_num, o.retire_reg, k);
            end
        end
    endtask

    task automatic test_redirect();
        snap_t o, e;
        do_reset();
        for (int i = 0; i < 5; i++) begin drive_dispatch(0); step(o, e); end
        drive_cmpl(0, 0, 1, 32'h40);
        step(o, e);
        step(o, e);
        n_checks++;
        if (o !== e || o.change_flow_out !== 1'b1 || o.change_flow_addr !== 32'h40) begin
            n_fail++; $display("FAIL redirect got cf=%b addr=%h exp 1 00000040", o.change_flow_out, o.change_flow_addr);
        end
        for (int k = 0; k < 4; k++) begin
            step(o, e);
            n_checks++;
            if (o !== e || o.recover !== 1'b1 || o.rec_rob_num !== IW'(4 - k) || o.change_flow_out !== 1'b0) begin
                n_fail++;
                $display("FAIL rollback_%0d got rec=%b rob=%0d cf=%b exp 1 %0d 0", k, o.recover, o.rec_rob_num, o.change_flow_out, 4 - k);
            end
        end
        drive_dispatch(0);
        step(o, e);
        n_checks++;
        if (o !== e || o.recover !== 1'b0 || o.empty !== 1'b1 || o.dp_accept !== 1'b1) begin
            n_fail++;
            $display("FAIL resume got rec=%b empty=%b acc=%b exp 0 1 1", o.recover, o.empty, o.dp_accept);
        end
    endtask

    task automatic test_wrap();
        snap_t o, e;
        int guard;
        logic [IW-1:0] want [4];
        want[0] = 4'd14; want[1] = 4'd15; want[2] = 4'd0; want[3] = 4'd1;
        do_reset();
        for (int j = 0; j <= 14; j++) begin
            if (j < 14) drive_dispatch(0);
            if (j >= 1) drive_cmpl(1, j - 1, 0, '0);
            step(o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL wrap_fill_%0d got %h exp %h", j, o, e); end
        end
        guard = 0;
        while (mq.size() > 0 && guard < 20) begin step(o, e); guard++; end
        n_checks++;
        if (mq.size() != 0 || o !== e) begin n_fail++; $display("FAIL wrap_drain got %h exp %h", o, e); end
        for (int k = 0; k < 4; k++) begin
            drive_dispatch(0);
            step(o, e);
            n_checks++;
            if (o !== e || o.dp_rob_num !== want[k] || o.dp_accept !== 1'b1) begin
                n_fail++; $display("FAIL wrap_rob_%0d got %0d exp %0d", k, o.dp_rob_num, want[k]);
            end
        end
        step(o, e);
        n_checks++;
        if (o.count !== 5'd4) begin n_fail++; $display("FAIL wrap_count got %0d exp 4", o.count); end
    endtask

    task automatic test_ignored_stall();
        snap_t o, e;
        do_reset();
        for (int i = 0; i < 2; i++) begin drive_dispatch(1); step(o, e); end
        drive_cmpl(0, 5, 1, 32'hdead_beef);
        drive_cmpl(1, 9, 0, '0);
        step(o, e);
        step(o, e);
        n_checks++;
        if (o !== e || o.count !== 5'd2 || o.retire_reg !== 1'b0 || o.change_flow_out !== 1'b0) begin
            n_fail++; $display("FAIL empty_slot_cmpl got %h exp %h", o, e);
        end
        drive_dispatch(1);
        hazard_stall = 1'b1;
        step(o, e);
        n_checks++;
        if (o.dp_accept !== 1'b0) begin n_fail++; $display("FAIL stall_accept got %b exp 0", o.dp_accept); end
        step(o, e);
        n_checks++;
        if (o !== e || o.dp_rob_num !== 4'd2 || o.count !== 5'd2) begin
            n_fail++; $display("FAIL stall_tail got rob=%0d count=%0d exp 2 2", o.dp_rob_num, o.count);
        end
    endtask

    task automatic test_random();
        snap_t o, e;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) != 0) drive_dispatch(0);
            hazard_stall = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < NCMPL; k++) begin
                if ($urandom_range(0, 1) == 1)
                    drive_cmpl(k, $urandom_range(0, DEPTH - 1), ($urandom_range(0, 15) == 0), $urandom);
            end
            step(o, e);
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL random_%0d got %h exp %h", c, o, e); end
        end
    endtask

    task automatic test_reset_recover();
        snap_t o, e, r;
        r = '0;
        r.empty = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin drive_dispatch(0); step(o, e); end
        drive_cmpl(1, 0, 1, 32'h1234);
        step(o, e);
        step(o, e);
        step(o, e);
        n_checks++;
        if (o.recover !== 1'b1) begin n_fail++; $display("FAIL rr_in_recover got %b exp 1", o.recover); end
        rst = 1'b1;
        #2;
        n_checks++;
        if (snap !== r) begin n_fail++; $display("FAIL rr_reset got %h exp %h", snap, r); end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        step(o, e);
        n_checks++;
        if (o !== e || o.state !== 1'b0 || o.recover !== 1'b0) begin
            n_fail++; $display("FAIL rr_idle got %h exp %h", o, e);
        end
        drive_dispatch(0);
        step(o, e);
        n_checks++;
        if (o !== e || o.dp_accept !== 1'b1 || o.dp_rob_num !== 4'd0) begin
            n_fail++; $display("FAIL rr_dispatch got acc=%b rob=%0d exp 1 0", o.dp_accept, o.dp_rob_num);
        end
    endtask

    initial begin
        clear_inputs();
        model_clear();
        test_reset();
        test_fill_drain();
        test_out_of_order();
        test_redirect();
        test_wrap();
        test_ignored_stall();
        test_random();
        test_reset_recover();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rob_multi_cmpl.md
# rob_multi_cmpl

Parametrised reorder buffer for the out-of-order core, sitting between dispatch (map table / free list) and the completion network. It accepts one dispatched instruction per cycle, takes completions from `NCMPL` independent completion ports, and retires in order one per cycle. On a retiring control-flow change it redirects fetch and performs a serial rollback, youngest first, so the map table and free list can restore state.

## Interface
- `DEPTH`, 16: entry count; power of two, ≥ 2; `IW = clog2(DEPTH)`
- `PREG_W`, 6: physical register tag width
- `NCMPL`, 2: number of completion ports
- `ADDR_W`, 32: jump/branch target width

Ports:
- `clk` in 1: clock; single clock domain
- `rst` in 1: asynchronous, active-high reset
- `dp_valid` in 1: dispatch request
- `hazard_stall` in 1: blocks dispatch this cycle
- `dp_is_st`, `dp_reg_dest` in 1 each: store flag; instruction writes a register
- `dp_rd` in 5: logical destination
- `dp_pr_old`, `dp_pr_new` in PREG_W: previous and new physical mapping
- `dp_rob_num` out IW: tail index given to the dispatching instruction
- `dp_accept` out 1: dispatch taken this cycle
- `cmpl_valid` in NCMPL: per-port completion strobe
- `cmpl_rob_num` in NCMPL*IW: per-port entry index; port k occupies bits [k*IW +: IW]
- `cmpl_change_flow` in NCMPL: per-port redirect flag
- `cmpl_jb_addr` in NCMPL*ADDR_W: per-port redirect target
- `retire_reg`, `retire_st` out 1 each: head retires a register writer; head retires a store
- `retire_reg_dest` out 1, `retire_pr_old` out PREG_W, `retire_rob_num` out IW: retiring entry fields
- `change_flow_out` out 1, `change_flow_addr` out ADDR_W: fetch redirect
- `recover` out 1: rollback entry valid
- `rec_reg_dest` out 1, `rec_rd` out 5, `rec_pr_old` out PREG_W, `rec_pr_new` out PREG_W, `rec_rob_num` out IW: rollback entry fields
- `full`, `empty` out 1 each; `count` out IW+1

## Operation
- Circular buffer with `head`/`tail` pointers of IW+1 bits; the extra bit is the wrap bit.
  - `full` when the indices are equal and the wrap bits differ.
  - `empty` when the pointers are fully equal.
  - `count = tail - head`, computed modulo 2^(IW+1).
- Entry fields: `valid`, `done`, `is_st`, `reg_dest`, `rd`, `pr_old`, `pr_new`, `cf`, `jb_addr`.
- Dispatch: `dp_accept = dp_valid & ~hazard_stall & ~full & (state==IDLE)`.
  - An accepted dispatch writes the entry at `tail` with `done=0`, `cf=0`, then increments `tail`.
  - `full` is evaluated before any same-cycle retire. A full ROB never accepts dispatch, even if it is retiring that cycle.
- Completion: each port with `cmpl_valid[k]` whose target entry is valid sets `done`.
  - A port with `cmpl_change_flow[k]` also sets `cf` and loads `jb_addr`.
  - Completion to an invalid entry is ignored.
  - Two ports hitting the same entry: `done`/`cf` are ORed, and the lowest-numbered port with `cf` supplies `jb_addr`.
- FSM states: IDLE, RECOVER.
  - **IDLE, retire:** when the head entry is valid and done, assert `retire_reg = reg_dest` and `retire_st = is_st`. At the clock edge, clear the entry and increment `head`.
  - **IDLE, control-flow change:** if the retiring head also has `cf`, assert `change_flow_out`/`change_flow_addr` in the same cycle. If any younger entries remain, go to RECOVER; otherwise stay in IDLE.
  - **RECOVER:** each cycle, assert `recover` with the fields of entry `tail-1`. At the clock edge, invalidate that entry and decrement `tail`. When `tail-1 == head`, return to IDLE. Dispatch and retire are blocked; completions still update entries harmlessly.
- Reset mid-operation: all entries are invalidated, pointers return to 0, the FSM returns to IDLE, and any rollback in progress is abandoned.

## Timing
- Reset values: all outputs 0, except `empty=1`; `dp_rob_num=0`, `count=0`.
- `dp_rob_num`, `dp_accept`, `full`, `empty`, `count` and all retire/recover outputs are combinational from registered state. Only `dp_accept` also depends on the current-cycle dispatch and stall inputs.
- Completion in cycle C allows retire in cycle C+1 at the earliest.
- Redirect: `change_flow_out` is high for exactly one cycle, the retire cycle of the branch.
- Rollback of N younger entries takes N cycles: `recover` is high for N consecutive cycles beginning the cycle after the redirect. Dispatch resumes the cycle after the last `recover`.
- Pointer wrap: index DEPTH-1 is followed by index 0, with the wrap bit toggled.

## Structure
- Shared package `rob_pkg`:
  - FSM state encoding (IDLE, RECOVER)
  - entry field widths
  - helper constant `IW` derivation
- Sub-module `rob_ptr_ctrl`: head/tail wrap-bit counters, full/empty/count logic. Supports increment and decrement of `tail`.
- Entry storage and completion merge stay in the top module.

## Test plan
- **Fill and drain.** Reset, then dispatch 16 instructions with DEPTH=16.
  - Required: `full=1`, `count=16`, and a 17th `dp_valid` gives `dp_accept=0`.
  - Then complete all entries in order: expect 16 retires in order over 16 cycles, `retire_pr_old` matching dispatch order, and a final `empty=1`.
- **Out-of-order completion.** Dispatch 3 entries; complete rob 2 and rob 1 on ports 0/1 in the same cycle, then complete rob 0.
  - Required: rob 0, 1, 2 retire on 3 consecutive cycles.
- **Redirect with rollback.** Dispatch 5 entries; complete rob 0 with `cf` and addr 0x40.
  - Required: `change_flow_out=1`, addr 0x40, for one cycle.
  - Then `recover` for 4 cycles with `rec_rob_num` 4, 3, 2, 1; afterwards `empty=1` and dispatch resumes.
- **Wrap-around.** Dispatch and retire 14 entries, then dispatch 4 more.
  - Required: `dp_rob_num` sequence 14, 15, 0, 1; `count=4`.
- **Ignored and stalled inputs.**
  - Completion to an empty slot: no state change.
  - `hazard_stall=1` with `dp_valid=1`: `dp_accept=0` and `tail` unchanged.
- **Reset during RECOVER.** Assert `rst` during RECOVER.
  - Required: all outputs at reset values immediately, FSM in IDLE after release.
